// File: rtl/sgn_alu_pkg.sv
// Shared types and helpers for the pipelined signed add/sub/accumulate unit.
package sgn_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD      = 3'b000,
        OP_ADD_IMM  = 3'b001,
        OP_IMM_ADD  = 3'b010,
        OP_SUB      = 3'b011,
        OP_ACC_ADD  = 3'b100,
        OP_ACC_LOAD = 3'b101,
        OP_ACC_SUB  = 3'b110,
        OP_ILLEGAL  = 3'b111
    } op_e;

    // Sign-extend the low `width` bits of value to 64 bits; callers size-cast the result.
    function automatic logic [63:0] sext(input logic [63:0] value, input int width);
        logic [63:0] mask;
        mask = ~64'd0 << width;
        return value[width-1] ? (value | mask) : (value & ~mask);
    endfunction

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/sgn_alu_pipe_if.sv
// Operand/result handshake bundle between operand fetch, the ALU pipe and writeback.
interface sgn_alu_pipe_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_d1;
    logic [DATA_W-1:0] in_d2;
    logic [IMM_W-1:0]  in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   out_d;
    logic              out_ovf;
    logic              out_err;
    logic [DATA_W:0]   acc_q;

    modport master (
        output in_valid, in_op, in_d1, in_d2, in_imm, out_ready,
        input  in_ready, out_valid, out_d, out_ovf, out_err, acc_q
    );

    modport slave (
        input  in_valid, in_op, in_d1, in_d2, in_imm, out_ready,
        output in_ready, out_valid, out_d, out_ovf, out_err, acc_q
    );
endinterface

// File: rtl/sgn_alu_stage.sv
// Generic valid/ready register slice; ready upstream is combinational from ready downstream.
module sgn_alu_stage #(
    parameter type payload_t = logic
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     up_valid,
    output logic     up_ready,
    input  payload_t up_data,
    output logic     dn_valid,
    input  logic     dn_ready,
    output payload_t dn_data
);
    logic     valid_reg;
    payload_t data_reg;

    assign up_ready = !valid_reg || dn_ready;
    assign dn_valid = valid_reg;
    assign dn_data  = data_reg;

    // Data only changes on a real transfer, so it holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (up_ready) begin
            valid_reg <= up_valid;
            if (up_valid) begin
                data_reg <= up_data;
            end
        end
    end
endmodule

// File: rtl/sgn_alu_pipe.sv
// Two-stage signed add/sub/accumulate pipe: S1 registers selected operands, S2 registers the result.
module sgn_alu_pipe
    import sgn_alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6,
    parameter bit SAT_EN = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    sgn_alu_pipe_if.slave bus
);
    localparam int RW = DATA_W + 1;
    localparam int SW = DATA_W + 2;
    localparam logic [RW-1:0] ACC_MAX = RW'(sat_max(RW));
    localparam logic [RW-1:0] ACC_MIN = RW'(sat_min(RW));

    typedef struct packed {
        op_e           op;
        logic [RW-1:0] a;
        logic [RW-1:0] b;
    } s1_t;

    typedef struct packed {
        logic [RW-1:0] d;
        logic          ovf;
        logic          err;
    } s2_t;

    s1_t           s1_in, s1_q;
    s2_t           s2_in, s2_q;
    logic          s1_valid, s2_load;
    logic [RW-1:0] acc_reg, acc_next;
    logic          acc_op;
    logic [SW-1:0] sum_w;

    // Operand select happens ahead of S1 so the stage only carries two operands.
    always_comb begin
        s1_in    = '0;
        s1_in.op = op_e'(bus.in_op);
        s1_in.a  = RW'(sext(64'(bus.in_d1), DATA_W));
        s1_in.b  = RW'(sext(64'(bus.in_d2), DATA_W));
        if (s1_in.op == OP_ADD_IMM) begin
            s1_in.b = RW'(sext(64'(bus.in_imm), IMM_W));
        end
        if (s1_in.op == OP_IMM_ADD) begin
            s1_in.a = RW'(sext(64'(bus.in_imm), IMM_W));
        end
    end

    always_comb begin
        s2_in    = '0;
        acc_next = acc_reg;
        acc_op   = 1'b0;
        sum_w    = '0;
        case (s1_q.op)
            OP_ADD, OP_ADD_IMM, OP_IMM_ADD: s2_in.d = s1_q.a + s1_q.b;
            OP_SUB:                         s2_in.d = s1_q.a - s1_q.b;
            OP_ACC_LOAD: begin
                acc_op   = 1'b1;
                acc_next = s1_q.a;
            end
            OP_ACC_ADD, OP_ACC_SUB: begin
                acc_op = 1'b1;
                // One guard bit: overflow shows as disagreement of the top two sum bits.
                if (s1_q.op == OP_ACC_ADD) begin
                    sum_w = {acc_reg[RW-1], acc_reg} + {s1_q.a[RW-1], s1_q.a};
                end else begin
                    sum_w = {acc_reg[RW-1], acc_reg} - {s1_q.a[RW-1], s1_q.a};
                end
                s2_in.ovf = sum_w[SW-1] ^ sum_w[SW-2];
                if (s2_in.ovf && SAT_EN) begin
                    acc_next = sum_w[SW-1] ? ACC_MIN : ACC_MAX;
                end else begin
                    acc_next = sum_w[RW-1:0];
                end
            end
            default: s2_in.err = 1'b1;
        endcase
        if (acc_op) begin
            s2_in.d = acc_next;
        end
    end

    // Commit on the S1->S2 move so the next accumulate op in S1 already sees the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (s1_valid && s2_load && acc_op) begin
            acc_reg <= acc_next;
        end
    end

    sgn_alu_stage #(.payload_t(s1_t)) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (bus.in_valid),
        .up_ready (bus.in_ready),
        .up_data  (s1_in),
        .dn_valid (s1_valid),
        .dn_ready (s2_load),
        .dn_data  (s1_q)
    );

    sgn_alu_stage #(.payload_t(s2_t)) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (s1_valid),
        .up_ready (s2_load),
        .up_data  (s2_in),
        .dn_valid (bus.out_valid),
        .dn_ready (bus.out_ready),
        .dn_data  (s2_q)
    );

    assign bus.out_d   = s2_q.d;
    assign bus.out_ovf = s2_q.ovf;
    assign bus.out_err = s2_q.err;
    assign bus.acc_q   = acc_reg;
endmodule
